// File: rtl/string_reader_pkg.sv
// rtl/string_reader_pkg.sv - shared state encodings and character constants for string_reader
package string_reader_pkg;

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } rx_state_t;

   typedef enum logic {
      ASM_COLLECT = 1'b0,
      ASM_DISCARD = 1'b1
   } asm_state_t;

   localparam logic [7:0] CHAR_LF = 8'h0A;
   localparam logic [7:0] CHAR_CR = 8'h0D;

endpackage

// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - 8N1 UART byte receiver with input synchronizer and stop-bit check
module uart_rx_byte
   import string_reader_pkg::*;
#(
   parameter int CLK_FREQ = 50000000,
   parameter int BAUD     = 115200
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] byte_data,
   output logic       byte_valid,
   output logic       frame_err
);

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
   localparam int HALF_BIT     = CLKS_PER_BIT / 2;
   localparam int CW           = $clog2(CLKS_PER_BIT + 1);

   rx_state_t      r_state;
   rx_state_t      w_next;
   logic           r_sync1, r_sync2, r_prev;
   logic [CW-1:0]  r_cnt;
   logic [2:0]     r_bit_idx;
   logic [7:0]     r_shift;
   logic [7:0]     r_byte;
   logic           r_byte_valid;
   logic           r_frame_err;
   logic           w_tick_half;
   logic           w_tick_bit;

   assign w_tick_half = (r_cnt == CW'(HALF_BIT - 1));
   assign w_tick_bit  = (r_cnt == CW'(CLKS_PER_BIT - 1));

   always_ff @(posedge clk) begin
      if (rst) r_state <= RX_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         RX_IDLE:  if (r_prev && !r_sync2) w_next = RX_START;
         RX_START: if (w_tick_half) w_next = r_sync2 ? RX_IDLE : RX_DATA;
         RX_DATA:  if (w_tick_bit && r_bit_idx == 3'd7) w_next = RX_STOP;
         RX_STOP:  if (w_tick_bit) w_next = RX_IDLE;
         default:  w_next = RX_IDLE;
      endcase
   end

   // r_prev is a third stage so the start edge is detected on synchronized data only
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1      <= 1'b1;
         r_sync2      <= 1'b1;
         r_prev       <= 1'b1;
         r_cnt        <= '0;
         r_bit_idx    <= '0;
         r_shift      <= '0;
         r_byte       <= '0;
         r_byte_valid <= 1'b0;
         r_frame_err  <= 1'b0;
      end else begin
         r_sync1      <= rx;
         r_sync2      <= r_sync1;
         r_prev       <= r_sync2;
         r_byte_valid <= 1'b0;
         r_frame_err  <= 1'b0;
         case (r_state)
            RX_IDLE: begin
               r_cnt     <= '0;
               r_bit_idx <= '0;
            end
            RX_START: r_cnt <= w_tick_half ? '0 : r_cnt + CW'(1);
            RX_DATA: begin
               if (w_tick_bit) begin
                  r_cnt     <= '0;
                  r_shift   <= {r_sync2, r_shift[7:1]};
                  r_bit_idx <= r_bit_idx + 3'd1;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            RX_STOP: begin
               if (w_tick_bit) begin
                  r_cnt <= '0;
                  if (r_sync2) begin
                     r_byte       <= r_shift;
                     r_byte_valid <= 1'b1;
                  end else begin
                     r_frame_err <= 1'b1;
                  end
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            default: r_cnt <= '0;
         endcase
      end
   end

   assign byte_data  = r_byte;
   assign byte_valid = r_byte_valid;
   assign frame_err  = r_frame_err;

endmodule

// File: rtl/string_reader.sv
// rtl/string_reader.sv - assembles UART bytes into newline-terminated lines with overflow flag
module string_reader
   import string_reader_pkg::*;
#(
   parameter int CLK_FREQ  = 50000000,
   parameter int BAUD      = 115200,
   parameter int MAX_CHARS = 82,
   localparam int LW       = $clog2(MAX_CHARS + 1)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   uart_rx,
   output logic [8*MAX_CHARS-1:0] line,
   output logic [LW-1:0]          line_len,
   output logic                   line_valid,
   output logic                   line_overflow,
   output logic                   frame_err
);

   localparam int BW = 8 * MAX_CHARS;

   logic [7:0]    w_byte;
   logic          w_byte_valid;
   logic          w_frame_err;
   asm_state_t    r_asm_state;
   asm_state_t    w_asm_next;
   logic          w_deliver;
   logic          w_append;
   logic [BW-1:0] r_buf;
   logic [LW-1:0] r_count;
   logic [BW-1:0] r_line;
   logic [LW-1:0] r_line_len;
   logic          r_line_valid;
   logic          r_line_overflow;

   uart_rx_byte #(
      .CLK_FREQ (CLK_FREQ),
      .BAUD     (BAUD)
   ) u_rx (
      .clk        (clk),
      .rst        (rst),
      .rx         (uart_rx),
      .byte_data  (w_byte),
      .byte_valid (w_byte_valid),
      .frame_err  (w_frame_err)
   );

   always_ff @(posedge clk) begin
      if (rst) r_asm_state <= ASM_COLLECT;
      else     r_asm_state <= w_asm_next;
   end

   always_comb begin
      w_asm_next = r_asm_state;
      w_deliver  = 1'b0;
      w_append   = 1'b0;
      if (w_byte_valid) begin
         case (r_asm_state)
            ASM_COLLECT: begin
               if (w_byte == CHAR_LF)             w_deliver  = 1'b1;
               else if (w_byte == CHAR_CR)        w_append   = 1'b0;
               else if (r_count < LW'(MAX_CHARS)) w_append   = 1'b1;
               else                               w_asm_next = ASM_DISCARD;
            end
            ASM_DISCARD: begin
               if (w_byte == CHAR_LF) begin
                  w_deliver  = 1'b1;
                  w_asm_next = ASM_COLLECT;
               end
            end
            default: w_asm_next = ASM_COLLECT;
         endcase
      end
   end

   // Shift-in keeps the buffer packed like a string literal: newest char in [7:0]
   always_ff @(posedge clk) begin
      if (rst) begin
         r_buf           <= '0;
         r_count         <= '0;
         r_line          <= '0;
         r_line_len      <= '0;
         r_line_valid    <= 1'b0;
         r_line_overflow <= 1'b0;
      end else begin
         r_line_valid <= 1'b0;
         if (w_deliver) begin
            r_line          <= r_buf;
            r_line_len      <= r_count;
            r_line_overflow <= (r_asm_state == ASM_DISCARD);
            r_line_valid    <= 1'b1;
            r_buf           <= '0;
            r_count         <= '0;
         end else if (w_append) begin
            r_buf   <= (r_buf << 8) | BW'(w_byte);
            r_count <= r_count + LW'(1);
         end
      end
   end

   assign line          = r_line;
   assign line_len      = r_line_len;
   assign line_valid    = r_line_valid;
   assign line_overflow = r_line_overflow;
   assign frame_err     = w_frame_err;

endmodule

// File: doc/string_reader.md
STRING_READER -- requirements
Module: string_reader

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50000000, clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, UART bit rate; CLKS_PER_BIT = CLK_FREQ/BAUD (integer division).
REQ-003 SHALL have parameter MAX_CHARS, default 82, line buffer capacity in characters; LW = clog2(MAX_CHARS+1).
REQ-004 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port uart_rx  input  1  asynchronous UART serial input, 8N1, idle high.
REQ-007 SHALL have port line  output  8*MAX_CHARS  last completed line, packed like a Verilog string literal: first char most significant, last char in bits [7:0], zero-filled above.
REQ-008 SHALL have port line_len  output  LW  number of characters in line.
REQ-009 SHALL have port line_valid  output  1  one-cycle pulse when line/line_len update.
REQ-010 SHALL have port line_overflow  output  1  set with line_valid when the delivered line was truncated.
REQ-011 SHALL have port frame_err  output  1  one-cycle pulse when a received byte has stop bit 0.

Function
REQ-012 SHALL pass uart_rx through a two-flop synchronizer before use.
REQ-013 Receiver states SHALL be IDLE, START, DATA, STOP.
REQ-014 IDLE->START on synchronized high-to-low transition; bit counter cleared.
REQ-015 START: at CLKS_PER_BIT/2 cycles, if line low -> DATA, else -> IDLE (glitch rejected, no byte, no error).
REQ-016 DATA: sample every CLKS_PER_BIT cycles, 8 bits, LSB first; after 8th sample -> STOP.
REQ-017 STOP: sample after CLKS_PER_BIT; 1 -> internal byte_valid pulse with byte; 0 -> frame_err pulse, byte dropped; then -> IDLE.
REQ-018 Assembler states SHALL be COLLECT and DISCARD.
REQ-019 COLLECT, byte 0x0D: ignored.
REQ-020 COLLECT, byte 0x0A: cycle after byte_valid, line <= buffer, line_len <= count, line_valid=1, line_overflow=0; buffer and count cleared.
REQ-021 COLLECT, other byte with count<MAX_CHARS: shift buffer left 8 bits, insert byte in [7:0], count+1.
REQ-022 COLLECT, other byte with count==MAX_CHARS: byte dropped, -> DISCARD.
REQ-023 DISCARD: all bytes except 0x0A dropped; on 0x0A deliver line as REQ-020 but line_overflow=1, -> COLLECT.
REQ-024 Empty line (0x0A with count 0) SHALL deliver line_valid with line_len=0, line all zeros.
REQ-025 line, line_len, line_overflow SHALL hold stable between line_valid pulses; no backpressure, consumer samples on pulse.
REQ-026 Framing-errored bytes SHALL not affect buffer, count or assembler state.
REQ-027 line_valid latency SHALL be exactly one clk after byte_valid of the terminating 0x0A.

Reset
REQ-028 rst SHALL return receiver to IDLE, assembler to COLLECT, synchronizer flops to 1.
REQ-029 rst SHALL clear line, line_len, line_valid, line_overflow, frame_err, buffer, count to 0.
REQ-030 rst mid-frame or mid-line SHALL discard partial byte and partial line; no pulse emitted.

Structure
REQ-031 Shared package SHALL hold receiver and assembler state encodings and constants 0x0A, 0x0D.
REQ-032 Bit-level receiver SHALL be sub-module uart_rx_byte (clk, rst, rx, byte, byte_valid, frame_err); assembler in string_reader.

Verification (CLK_FREQ=1000000, BAUD=100000, MAX_CHARS=4, 10 clk/bit)
REQ-033 Send "Hi\r\n" -> one line_valid, line=32'h00004869, line_len=2, line_overflow=0.
REQ-034 Send "ABCDEF\n" -> line=32'h41424344, line_len=4, line_overflow=1; next "Z\n" -> line=32'h0000005A, len=1, overflow=0.
REQ-035 Send "\n" -> line_valid, line_len=0, line=0.
REQ-036 Send 'A' with stop bit 0, then "B\n" -> one frame_err pulse, then line=32'h00000042, len=1.
REQ-037 3-clk low glitch on idle uart_rx, then "C\n" -> no frame_err, no extra byte, line=32'h00000043.
REQ-038 Assert rst during 2nd data bit of 'X' after "Q" received, then "R\n" -> no pulse during reset, line=32'h00000052, len=1.
